// File: rtl/shift_cmd_feeder.sv
// shift_cmd_feeder
// Streaming front end for a combinational 8-bit barrel shifter.
// Commands are queued in a small FIFO and then issued one at a time on
// registered operand ports (S1). The shifter result is captured into a
// valid/ready output register (S2).
// Data path: FIFO -> S1 (sh_*) -> external shifter -> S2 (out_*).
// There is no bypass path, so every command takes at least two cycles
// from acceptance to result, and results leave in acceptance order.

module shift_cmd_feeder #(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,

  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_data,
  input  logic [2:0]    in_shamt,
  input  logic [1:0]    in_type,

  output logic [7:0]    sh_data,
  output logic [2:0]    sh_shamt,
  output logic [1:0]    sh_type,
  output logic          sh_valid,
  input  logic [7:0]    sh_result,

  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,

  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 13;

  // FIFO storage and pointers
  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // Issue stage S1
  logic [7:0]    sh_data_q,  sh_data_d;
  logic [2:0]    sh_shamt_q, sh_shamt_d;
  logic [1:0]    sh_type_q,  sh_type_d;
  logic          sh_valid_q, sh_valid_d;

  // Output stage S2
  logic [7:0]    out_data_q,  out_data_d;
  logic          out_valid_q, out_valid_d;

  logic          fifo_full;
  logic          fifo_empty;
  logic          push;
  logic          adv1;
  logic          adv2;
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head_entry;

  // Full and empty come only from the registered count, so in_ready never
  // depends combinationally on in_valid or out_ready.
  assign fifo_full  = (count_q == CW'(DEPTH));
  assign fifo_empty = (count_q == '0);

  assign in_ready   = ~fifo_full;
  assign push       = in_valid & ~fifo_full;

  // S2 takes a new result whenever S1 is live and S2 is empty or draining.
  // S1 pops the FIFO whenever S1 is empty or is handing its command to S2.
  assign adv2       = sh_valid_q & (~out_valid_q | out_ready);
  assign adv1       = ~fifo_empty & (~sh_valid_q | adv2);

  assign wr_entry   = {in_type, in_shamt, in_data};
  assign head_entry = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
  // pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (adv1) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    count_d = count_q + CW'(push) - CW'(adv1);
  end

  // Issue stage: load the FIFO head on a pop; otherwise go empty once the
  // command has moved on to S2. The operands hold their value when idle.
  always_comb begin
    sh_data_d  = sh_data_q;
    sh_shamt_d = sh_shamt_q;
    sh_type_d  = sh_type_q;
    sh_valid_d = sh_valid_q;
    if (adv1) begin
      sh_data_d  = head_entry[7:0];
      sh_shamt_d = head_entry[10:8];
      sh_type_d  = head_entry[12:11];
      sh_valid_d = 1'b1;
    end else if (adv2) begin
      sh_valid_d = 1'b0;
    end
  end

  // Output stage: capture the shifter result on advance, otherwise retire
  // on a downstream handshake. The data holds while the output is stalled.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (adv2) begin
      out_data_d  = sh_result;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // FIFO array write. The array needs no reset because an entry is only
  // read after it has been written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  // Control and pipeline registers. Reset discards all queued work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sh_data_q   <= '0;
      sh_shamt_q  <= '0;
      sh_type_q   <= '0;
      sh_valid_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sh_data_q   <= sh_data_d;
      sh_shamt_q  <= sh_shamt_d;
      sh_type_q   <= sh_type_d;
      sh_valid_q  <= sh_valid_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign sh_data   = sh_data_q;
  assign sh_shamt  = sh_shamt_q;
  assign sh_type   = sh_type_q;
  assign sh_valid  = sh_valid_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign count     = count_q;

endmodule

// File: tb/tb_shift_cmd_feeder.sv
// Directed and randomised bench for shift_cmd_feeder. The shifter sitting
// downstream of the feeder is modelled behaviourally here. Inputs are
// driven and outputs are sampled on the falling clock edge.

module tb_shift_cmd_feeder;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic [2:0]    in_shamt;
  logic [1:0]    in_type;
  logic [7:0]    sh_data;
  logic [2:0]    sh_shamt;
  logic [1:0]    sh_type;
  logic          sh_valid;
  logic [7:0]    sh_result;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic [CW-1:0] count;

  int n_pass;
  int n_total;

  shift_cmd_feeder #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_type   (in_type),
    .sh_data   (sh_data),
    .sh_shamt  (sh_shamt),
    .sh_type   (sh_type),
    .sh_valid  (sh_valid),
    .sh_result (sh_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference shifter: 00 shl, 01 shr, 10 rotl, 11 rotr.
  function automatic logic [7:0] shf(input logic [7:0] d, input logic [2:0] s,
                                     input logic [1:0] t);
    logic [3:0] inv;
    inv = 4'd8 - {1'b0, s};
    case (t)
      2'b00:   shf = d << s;
      2'b01:   shf = d >> s;
      2'b10:   shf = (d << s) | (d >> inv);
      default: shf = (d >> s) | (d << inv);
    endcase
  endfunction

  always_comb sh_result = shf(sh_data, sh_shamt, sh_type);

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_shamt = '0; in_type = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_total += 8;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    if (sh_valid !== 1'b0) $display("FAIL reset_sh_valid: got %b want 0", sh_valid); else n_pass++;
    if (sh_data !== 8'h00) $display("FAIL reset_sh_data: got %h want 00", sh_data); else n_pass++;
    if (sh_shamt !== 3'd0) $display("FAIL reset_sh_shamt: got %h want 0", sh_shamt); else n_pass++;
    if (sh_type !== 2'd0) $display("FAIL reset_sh_type: got %h want 0", sh_type); else n_pass++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    if (out_data !== 8'h00) $display("FAIL reset_out_data: got %h want 00", out_data); else n_pass++;
    if (count !== '0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // 0xB3 shamt 2, four types back to back; results on consecutive cycles.
  task automatic test_stream();
    logic [7:0] exp_d [8];
    logic       exp_v [8];
    exp_v = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_d = '{8'h00, 8'h00, 8'hCC, 8'h2C, 8'hCE, 8'hEC, 8'h00, 8'h00};
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        in_valid = 1'b1; in_data = 8'hB3; in_shamt = 3'd2; in_type = 2'(k);
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      n_total++;
      if (out_valid !== exp_v[k])
        $display("FAIL stream_out_valid[%0d]: got %b want %b", k, out_valid, exp_v[k]);
      else n_pass++;
      if (exp_v[k]) begin
        n_total++;
        if (out_data !== exp_d[k])
          $display("FAIL stream_out_data[%0d]: got %h want %h", k, out_data, exp_d[k]);
        else n_pass++;
      end
      if (k == 0) begin
        n_total += 2;
        if (count !== CW'(1)) $display("FAIL stream_count_e0: got %0d want 1", count); else n_pass++;
        if (sh_valid !== 1'b0) $display("FAIL stream_sh_valid_e0: got %b want 0", sh_valid); else n_pass++;
      end
      if (k == 1) begin
        n_total += 2;
        if (sh_valid !== 1'b1) $display("FAIL stream_sh_valid_e1: got %b want 1", sh_valid); else n_pass++;
        if (sh_data !== 8'hB3) $display("FAIL stream_sh_data_e1: got %h want b3", sh_data); else n_pass++;
      end
    end
  endtask

  // 0xB3 shamt 5: shl then rotl, must come back in order.
  task automatic test_order();
    logic [7:0] got [4];
    int n;
    got = '{8'h00, 8'h00, 8'h00, 8'h00};
    n = 0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'hB3; in_shamt = 3'd5; in_type = 2'b00;
    @(negedge clk);
    in_type = 2'b10;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid && out_ready) begin
        if (n < 4) got[n] = out_data;
        n++;
      end
      @(negedge clk);
    end
    n_total += 3;
    if (n != 2) $display("FAIL order_count: got %0d want 2", n); else n_pass++;
    if (got[0] !== 8'h60) $display("FAIL order_first: got %h want 60", got[0]); else n_pass++;
    if (got[1] !== 8'h76) $display("FAIL order_second: got %h want 76", got[1]); else n_pass++;
  endtask

  // Fill the feeder with out_ready low; returns the number accepted.
  task automatic fill(input logic [7:0] base, output int acc);
    acc = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 20 && in_ready; c++) begin
      in_valid = 1'b1; in_data = base + 8'(acc); in_shamt = 3'd0; in_type = 2'b00;
      acc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc;
    fill(8'hA0, acc);
    n_total += 5;
    if (acc != DEPTH + 2) $display("FAIL bp_accepted: got %0d want %0d", acc, DEPTH + 2); else n_pass++;
    if (count !== CW'(DEPTH)) $display("FAIL bp_count: got %0d want %0d", count, DEPTH); else n_pass++;
    if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else n_pass++;
    if (out_valid !== 1'b1) $display("FAIL bp_out_valid: got %b want 1", out_valid); else n_pass++;
    if (out_data !== 8'hA0) $display("FAIL bp_out_data: got %h want a0", out_data); else n_pass++;
    repeat (3) @(negedge clk);
    n_total += 2;
    if (out_valid !== 1'b1) $display("FAIL bp_hold_valid: got %b want 1", out_valid); else n_pass++;
    if (out_data !== 8'hA0) $display("FAIL bp_hold_data: got %h want a0", out_data); else n_pass++;
    out_ready = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 8'hA0 + 8'(k))
        $display("FAIL bp_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'hA0 + 8'(k));
      else n_pass++;
      @(negedge clk);
    end
    n_total += 2;
    if (out_valid !== 1'b0) $display("FAIL bp_drained_valid: got %b want 0", out_valid); else n_pass++;
    if (count !== '0) $display("FAIL bp_drained_count: got %0d want 0", count); else n_pass++;
  endtask

  // Full FIFO with push attempt and pop in the same cycle.
  task automatic test_full_simul();
    int acc;
    fill(8'h10, acc);
    in_valid = 1'b1; in_data = 8'hEE; in_shamt = 3'd0; in_type = 2'b00;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_total += 3;
    if (count !== CW'(DEPTH - 1)) $display("FAIL full_count: got %0d want %0d", count, DEPTH - 1); else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL full_in_ready: got %b want 1", in_ready); else n_pass++;
    if (acc != DEPTH + 2) $display("FAIL full_accepted: got %0d want %0d", acc, DEPTH + 2); else n_pass++;
    for (int k = 0; k < DEPTH + 1; k++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 + 8'(k))
        $display("FAIL full_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, out_valid, out_data, 8'h11 + 8'(k));
      else n_pass++;
      @(negedge clk);
    end
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL full_no_extra: got v=%b d=%h want v=0", out_valid, out_data); else n_pass++;
  endtask

  // Scoreboarded traffic. rnd=0 gives a fixed pattern (pointer wrap),
  // rnd=1 randomises valid and ready.
  task automatic test_traffic(input int n, input bit rnd);
    logic [7:0] exp_q [$];
    logic [7:0] prev_data;
    logic [7:0] e;
    bit prev_stall;
    int sent, rcvd, cyc, bound;
    sent = 0; rcvd = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0;
    bound = 20 * n + 100;
    while (rcvd < n && cyc < bound) begin
      if (prev_stall) begin
        n_total++;
        if (out_valid !== 1'b1 || out_data !== prev_data)
          $display("FAIL traffic_stall_hold: got v=%b d=%h want v=1 d=%h", out_valid, out_data, prev_data);
        else n_pass++;
      end
      n_total++;
      if (count > CW'(DEPTH)) $display("FAIL traffic_count_max: got %0d want <=%0d", count, DEPTH); else n_pass++;
      if (rnd) begin
        in_valid  = (sent < n) && ($urandom % 10 < 7);
        out_ready = ($urandom % 10 < 6);
        in_data   = 8'($urandom);
        in_shamt  = 3'($urandom);
        in_type   = 2'($urandom);
      end else begin
        in_valid  = (sent < n);
        out_ready = (cyc % 3 != 0);
        in_data   = 8'(sent * 37 + 5);
        in_shamt  = 3'(sent);
        in_type   = 2'(sent >> 1);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(shf(in_data, in_shamt, in_type));
        sent++;
      end
      if (out_valid && out_ready) begin
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL traffic_extra: got d=%h want no result", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) $display("FAIL traffic_data[%0d]: got %h want %h", rcvd, out_data, e);
          else n_pass++;
        end
        rcvd++;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      cyc++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    n_total += 2;
    if (rcvd != n) $display("FAIL traffic_received: got %0d want %0d", rcvd, n); else n_pass++;
    if (exp_q.size() != 0) $display("FAIL traffic_leftover: got %0d want 0", exp_q.size()); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL traffic_idle: got v=%b want 0", out_valid); else n_pass++;
  endtask

  // Asynchronous reset with 3 queued plus S1 and S2 occupied.
  task automatic test_reset_mid();
    logic [7:0] first;
    int n;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = 8'h40 + 8'(k); in_shamt = 3'd1; in_type = 2'b00;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_total += 3;
    if (count !== CW'(3)) $display("FAIL mid_pre_count: got %0d want 3", count); else n_pass++;
    if (sh_valid !== 1'b1) $display("FAIL mid_pre_sh_valid: got %b want 1", sh_valid); else n_pass++;
    if (out_valid !== 1'b1) $display("FAIL mid_pre_out_valid: got %b want 1", out_valid); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total += 5;
    if (count !== '0) $display("FAIL mid_count: got %0d want 0", count); else n_pass++;
    if (in_ready !== 1'b1) $display("FAIL mid_in_ready: got %b want 1", in_ready); else n_pass++;
    if (sh_valid !== 1'b0 || sh_data !== 8'h00) $display("FAIL mid_sh: got v=%b d=%h want v=0 d=00", sh_valid, sh_data); else n_pass++;
    if (out_valid !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", out_valid); else n_pass++;
    if (out_data !== 8'h00) $display("FAIL mid_out_data: got %h want 00", out_data); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; in_data = 8'h01; in_shamt = 3'd7; in_type = 2'b11;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0; first = 8'hFF;
    for (int c = 0; c < 10; c++) begin
      if (out_valid && out_ready) begin
        if (n == 0) first = out_data;
        n++;
      end
      @(negedge clk);
    end
    n_total += 2;
    if (n != 1) $display("FAIL mid_result_count: got %0d want 1", n); else n_pass++;
    if (first !== 8'h02) $display("FAIL mid_result_data: got %h want 02", first); else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_stream();
    test_order();
    test_backpressure();
    test_full_simul();
    test_traffic(3 * DEPTH, 1'b0);
    test_reset_mid();
    test_traffic(1000, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
